// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port unified memory between the core's instruction-fetch
//   port (IF) and its data-memory port (DM). One access is in flight at a time.
//   The arbiter issues the access, waits the fixed memory latency, and then
//   returns the response to whichever requester owns the access.
//
//   DM normally has priority. IF is protected from starvation: once
//   STARVE_LIMIT consecutive DM grants have been made while IF was waiting,
//   the next contested grant goes to IF.
//
// Ports
//   in_Clk, in_Rst_N           clock (rising edge), async active-low reset
//   in_if_req / in_if_addr     fetch request (held until out_if_gnt) and address
//   out_if_gnt                 fetch accepted this cycle (combinational)
//   out_if_rvalid/out_if_rdata fetch response pulse, 32-bit instruction word
//   in_dm_req/_wr/_addr/_wdata data request (held until out_dm_gnt)
//   out_dm_gnt                 data access accepted this cycle (combinational)
//   out_dm_rvalid/out_dm_rdata data response pulse (read data, 0 for writes)
//   out_mem_en/_wr_en/_addr/_wdata  memory strobe, write strobe, address, data
//   in_mem_rdata               memory read data, valid MEM_LATENCY cycles
//                              after the access strobe
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 64,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  in_Clk,
  input  logic                  in_Rst_N,
  input  logic                  in_if_req,
  input  logic [ADDR_WIDTH-1:0] in_if_addr,
  output logic                  out_if_gnt,
  output logic                  out_if_rvalid,
  output logic [31:0]           out_if_rdata,
  input  logic                  in_dm_req,
  input  logic                  in_dm_wr,
  input  logic [ADDR_WIDTH-1:0] in_dm_addr,
  input  logic [DATA_WIDTH-1:0] in_dm_wdata,
  output logic                  out_dm_gnt,
  output logic                  out_dm_rvalid,
  output logic [DATA_WIDTH-1:0] out_dm_rdata,
  output logic                  out_mem_en,
  output logic                  out_mem_wr_en,
  output logic [ADDR_WIDTH-1:0] out_mem_addr,
  output logic [DATA_WIDTH-1:0] out_mem_wdata,
  input  logic [DATA_WIDTH-1:0] in_mem_rdata
);

  // Latency counter holds MEM_LATENCY-1 down to 0; keep at least one bit.
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_r, state_nxt_s;
  logic             owner_dm_r, owner_dm_nxt_s;   // 1 = DM owns the access
  logic             addr2_r, addr2_nxt_s;         // selects IF word half
  logic             wr_r, wr_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [STV_W-1:0] starve_r, starve_nxt_s;

  logic                  if_starved_s;
  logic                  dm_win_s;
  logic                  if_gnt_s, dm_gnt_s;
  logic                  mem_en_s, mem_wr_en_s;
  logic [ADDR_WIDTH-1:0] mem_addr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;
  logic                  if_rvalid_s, dm_rvalid_s;
  logic [31:0]           if_rdata_s;
  logic [DATA_WIDTH-1:0] dm_rdata_s;

  // Arbitration decision: DM wins unless IF has been passed over too often.
  always_comb begin
    if_starved_s = (starve_r == STV_MAX);
    dm_win_s     = in_dm_req & ~(in_if_req & if_starved_s);
  end

  // Next-state logic, grants, memory strobes and response steering.
  always_comb begin
    state_nxt_s    = state_r;
    owner_dm_nxt_s = owner_dm_r;
    addr2_nxt_s    = addr2_r;
    wr_nxt_s       = wr_r;
    cnt_nxt_s      = cnt_r;
    if_gnt_s       = 1'b0;
    dm_gnt_s       = 1'b0;
    mem_en_s       = 1'b0;
    mem_wr_en_s    = 1'b0;
    mem_addr_s     = '0;
    mem_wdata_s    = '0;
    if_rvalid_s    = 1'b0;
    dm_rvalid_s    = 1'b0;
    if_rdata_s     = 32'h0000_0000;
    dm_rdata_s     = '0;
    case (state_r)
      IDLE: begin
        if (in_dm_req || in_if_req) begin
          mem_en_s    = 1'b1;
          cnt_nxt_s   = CNT_LOAD;
          state_nxt_s = BUSY;
          addr2_nxt_s = in_if_addr[2];
          wr_nxt_s    = in_dm_wr;
          if (dm_win_s) begin
            dm_gnt_s       = 1'b1;
            owner_dm_nxt_s = 1'b1;
            mem_addr_s     = in_dm_addr;
            mem_wr_en_s    = in_dm_wr;
            mem_wdata_s    = in_dm_wr ? in_dm_wdata : '0;
          end else begin
            if_gnt_s       = 1'b1;
            owner_dm_nxt_s = 1'b0;
            mem_addr_s     = in_if_addr;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == '0) begin
          state_nxt_s = IDLE;
          if (owner_dm_r) begin
            dm_rvalid_s = 1'b1;
            dm_rdata_s  = wr_r ? '0 : in_mem_rdata;
          end else begin
            if_rvalid_s = 1'b1;
            if_rdata_s  = addr2_r ? in_mem_rdata[DATA_WIDTH-1 -: 32]
                                  : in_mem_rdata[31:0];
          end
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Starvation counter: counts DM grants that overtook a waiting IF request.
  always_comb begin
    if (!in_if_req) begin
      starve_nxt_s = '0;
    end else if (if_gnt_s) begin
      starve_nxt_s = '0;
    end else if (dm_gnt_s && !if_starved_s) begin
      starve_nxt_s = starve_r + STV_W'(1);
    end else begin
      starve_nxt_s = starve_r;
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      state_r    <= IDLE;
      owner_dm_r <= 1'b0;
      addr2_r    <= 1'b0;
      wr_r       <= 1'b0;
      cnt_r      <= '0;
      starve_r   <= '0;
    end else begin
      state_r    <= state_nxt_s;
      owner_dm_r <= owner_dm_nxt_s;
      addr2_r    <= addr2_nxt_s;
      wr_r       <= wr_nxt_s;
      cnt_r      <= cnt_nxt_s;
      starve_r   <= starve_nxt_s;
    end
  end

  // Grants and strobes depend on live request inputs, so they are gated by
  // reset directly to stay quiet while reset is asserted.
  always_comb begin
    if (in_Rst_N) begin
      out_if_gnt    = if_gnt_s;
      out_dm_gnt    = dm_gnt_s;
      out_mem_en    = mem_en_s;
      out_mem_wr_en = mem_wr_en_s;
      out_mem_addr  = mem_addr_s;
      out_mem_wdata = mem_wdata_s;
      out_if_rvalid = if_rvalid_s;
      out_if_rdata  = if_rdata_s;
      out_dm_rvalid = dm_rvalid_s;
      out_dm_rdata  = dm_rdata_s;
    end else begin
      out_if_gnt    = 1'b0;
      out_dm_gnt    = 1'b0;
      out_mem_en    = 1'b0;
      out_mem_wr_en = 1'b0;
      out_mem_addr  = '0;
      out_mem_wdata = '0;
      out_if_rvalid = 1'b0;
      out_if_rdata  = 32'h0000_0000;
      out_dm_rvalid = 1'b0;
      out_dm_rdata  = '0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter (MEM_LATENCY=2, STARVE_LIMIT=4).
//   A table of single transactions is applied in a loop; expected responses
//   go into a scoreboard queue at grant time and are popped when the DUT
//   pulses rvalid. Hand-written sequences cover reset, contention,
//   starvation, dropped requests and reset during an access.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req, dm_wr;
  logic [63:0] dm_addr, dm_wdata;
  logic        dm_gnt, dm_rvalid;
  logic [63:0] dm_rdata;
  logic        mem_en, mem_wr_en;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        is_dm;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] mem_data;
    logic [63:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        is_dm;
    logic [63:0] rdata;
  } resp_t;

  vec_t  vecs[6];
  resp_t sb_q[$];

  mem_port_arbiter #(
    .DATA_WIDTH(64), .ADDR_WIDTH(64), .MEM_LATENCY(2), .STARVE_LIMIT(4)
  ) dut (
    .in_Clk(clk), .in_Rst_N(rst_n),
    .in_if_req(if_req), .in_if_addr(if_addr),
    .out_if_gnt(if_gnt), .out_if_rvalid(if_rvalid), .out_if_rdata(if_rdata),
    .in_dm_req(dm_req), .in_dm_wr(dm_wr), .in_dm_addr(dm_addr),
    .in_dm_wdata(dm_wdata),
    .out_dm_gnt(dm_gnt), .out_dm_rvalid(dm_rvalid), .out_dm_rdata(dm_rdata),
    .out_mem_en(mem_en), .out_mem_wr_en(mem_wr_en), .out_mem_addr(mem_addr),
    .out_mem_wdata(mem_wdata), .in_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Move to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic is_dm, input logic [63:0] rdata);
    resp_t r;
    r.is_dm = is_dm;
    r.rdata = rdata;
    sb_q.push_back(r);
  endtask

  // Compare the response visible this cycle against the scoreboard head.
  task automatic chk_resp(input string name);
    resp_t r;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty, got 0 entries expected 1", name);
    end else begin
      r = sb_q.pop_front();
      chk({name, "_if_rvalid"}, {63'd0, if_rvalid}, {63'd0, !r.is_dm});
      chk({name, "_dm_rvalid"}, {63'd0, dm_rvalid}, {63'd0, r.is_dm});
      chk({name, "_if_rdata"}, {32'd0, if_rdata}, r.is_dm ? 64'd0 : r.rdata);
      chk({name, "_dm_rdata"}, dm_rdata, r.is_dm ? r.rdata : 64'd0);
    end
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_mem_en"}, {63'd0, mem_en}, 64'd0);
    chk({name, "_gnt"}, {62'd0, if_gnt, dm_gnt}, 64'd0);
    chk({name, "_rvalid"}, {62'd0, if_rvalid, dm_rvalid}, 64'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 64'h104, 64'h0, 64'hAAAABBBB_11112222, 64'hAAAABBBB};
    vecs[1] = '{1'b0, 1'b0, 64'h100, 64'h0, 64'h12345678_9ABCDEF0, 64'h9ABCDEF0};
    vecs[2] = '{1'b1, 1'b0, 64'h2000, 64'h0, 64'h01234567_89ABCDEF,
                64'h01234567_89ABCDEF};
    vecs[3] = '{1'b1, 1'b1, 64'h10, 64'hDEADBEEF, 64'hFFFFFFFF_FFFFFFFF, 64'h0};
    vecs[4] = '{1'b1, 1'b0, 64'hFFFFFFFF_FFFFFFF8, 64'h0, 64'h80000000_00000001,
                64'h80000000_00000001};
    vecs[5] = '{1'b0, 1'b0, 64'hFFFFFFFF_FFFFFFFC, 64'h0, 64'hCAFEF00D_55AA55AA,
                64'hCAFEF00D};

    rst_n = 1'b0; if_req = 1'b1; if_addr = 64'h80; dm_req = 1'b1;
    dm_wr = 1'b0; dm_addr = 64'h40; dm_wdata = 64'h0; mem_rdata = 64'h0;

    // Reset with both requests pending: everything quiet, DM wins on release.
    cyc(); #3;
    chk_quiet("rst");
    chk("rst_wr_en", {63'd0, mem_wr_en}, 64'd0);
    cyc(); rst_n = 1'b1; #3;
    chk("rel_dm_gnt", {63'd0, dm_gnt}, 64'd1);
    chk("rel_if_gnt", {63'd0, if_gnt}, 64'd0);
    chk("rel_mem_addr", mem_addr, 64'h40);
    push(1'b1, 64'h0F0F_0F0F_0F0F_0F0F);
    cyc(); if_req = 1'b0; dm_req = 1'b0; #3;
    chk_quiet("rel_busy");
    cyc(); mem_rdata = 64'h0F0F_0F0F_0F0F_0F0F; #3;
    chk_resp("rel_resp");

    // Table-driven single transactions, issued back to back.
    for (int i = 0; i < 6; i++) begin
      cyc();
      if_req = !vecs[i].is_dm; if_addr = vecs[i].is_dm ? 64'h0 : vecs[i].addr;
      dm_req = vecs[i].is_dm;  dm_addr = vecs[i].is_dm ? vecs[i].addr : 64'h0;
      dm_wr = vecs[i].wr; dm_wdata = vecs[i].wdata; mem_rdata = 64'h0;
      #3;
      chk($sformatf("v%0d_gnt", i), {62'd0, if_gnt, dm_gnt},
          vecs[i].is_dm ? 64'd1 : 64'd2);
      chk($sformatf("v%0d_mem_en", i), {63'd0, mem_en}, 64'd1);
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].addr);
      chk($sformatf("v%0d_wr_en", i), {63'd0, mem_wr_en},
          {63'd0, vecs[i].is_dm & vecs[i].wr});
      chk($sformatf("v%0d_wdata", i), mem_wdata,
          (vecs[i].is_dm && vecs[i].wr) ? vecs[i].wdata : 64'h0);
      push(vecs[i].is_dm, vecs[i].exp_rdata);
      // Inputs change while busy; the latched values must be used.
      cyc(); if_req = 1'b0; dm_req = 1'b0; if_addr = ~if_addr; dm_wr = ~dm_wr;
      mem_rdata = 64'h5A5A_5A5A_5A5A_5A5A; #3;
      chk_quiet($sformatf("v%0d_busy", i));
      chk($sformatf("v%0d_busy_wr_en", i), {63'd0, mem_wr_en}, 64'd0);
      cyc(); mem_rdata = vecs[i].mem_data; #3;
      chk_resp($sformatf("v%0d_resp", i));
    end

    // Simultaneous requests: DM at T, response at T+2, IF at T+3.
    cyc(); if_req = 1'b1; if_addr = 64'h208; dm_req = 1'b1; dm_addr = 64'h300;
    dm_wr = 1'b0; #3;
    chk("both_gnt", {62'd0, if_gnt, dm_gnt}, 64'd1);
    push(1'b1, 64'h1122_3344_5566_7788);
    cyc(); dm_req = 1'b0; #3;
    chk("both_t1_if_gnt", {63'd0, if_gnt}, 64'd0);
    cyc(); mem_rdata = 64'h1122_3344_5566_7788; #3;
    chk("both_t2_if_gnt", {63'd0, if_gnt}, 64'd0);
    chk_resp("both_dm_resp");
    cyc(); #3;
    chk("both_t3_if_gnt", {63'd0, if_gnt}, 64'd1);
    chk("both_t3_addr", mem_addr, 64'h208);
    push(1'b0, 64'h5566_7788);
    cyc(); if_req = 1'b0; #3;
    cyc(); #3;
    chk_resp("both_if_resp");

    // Starvation: DM at T, T+3, T+6, T+9, then IF at T+12.
    for (int k = 0; k <= 14; k++) begin
      cyc();
      if (k == 0) begin
        if_req = 1'b1; if_addr = 64'h600; dm_req = 1'b1; dm_addr = 64'h700;
      end else if (k == 13) begin
        if_req = 1'b0; dm_req = 1'b0;
      end else begin
        mem_rdata = 64'h0;
      end
      #3;
      chk($sformatf("stv%0d_dm_gnt", k), {63'd0, dm_gnt},
          {63'd0, (k % 3 == 0) && (k < 12)});
      chk($sformatf("stv%0d_if_gnt", k), {63'd0, if_gnt}, {63'd0, k == 12});
      chk($sformatf("stv%0d_if_rvalid", k), {63'd0, if_rvalid}, {63'd0, k == 14});
    end

    // A DM request raised and dropped while busy is never issued.
    cyc(); if_req = 1'b1; if_addr = 64'h800; #3;
    chk("drop_if_gnt", {63'd0, if_gnt}, 64'd1);
    push(1'b0, 64'h0000_0001);
    cyc(); if_req = 1'b0; dm_req = 1'b1; dm_addr = 64'h900; #3;
    chk("drop_busy_gnt", {63'd0, dm_gnt}, 64'd0);
    cyc(); dm_req = 1'b0; mem_rdata = 64'h0000_0002_0000_0001; #3;
    chk_resp("drop_resp");
    cyc(); #3;
    chk_quiet("drop_after");

    // Reset during an IF access: no IF response, DM granted after release.
    cyc(); if_req = 1'b1; if_addr = 64'hA04; #3;
    chk("rmid_if_gnt", {63'd0, if_gnt}, 64'd1);
    cyc(); rst_n = 1'b0; if_req = 1'b0; dm_req = 1'b1; dm_addr = 64'hB00; #3;
    chk_quiet("rmid_rst");
    cyc(); rst_n = 1'b1; mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD; #3;
    chk("rmid_if_rvalid", {63'd0, if_rvalid}, 64'd0);
    chk("rmid_dm_gnt", {63'd0, dm_gnt}, 64'd1);
    chk("rmid_addr", mem_addr, 64'hB00);
    push(1'b1, 64'h7777_6666_5555_4444);
    cyc(); dm_req = 1'b0; #3;
    chk("rmid_busy_if_rvalid", {63'd0, if_rvalid}, 64'd0);
    cyc(); mem_rdata = 64'h7777_6666_5555_4444; #3;
    chk_resp("rmid_resp");

    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
